inst_axi_read_master: RTL and testbench

Bridges the L1 instruction cache refill port onto an AXI4 read channel. On a cache miss the cache holds `I_req` with a line-aligned `I_addr`. This block then issues one 4-beat INCR burst and returns each 32-bit word to the cache as a one-cycle `I_wait`-low pulse. It sits directly downstream of the instruction cache and upstream of the AXI interconnect, as the read-only instruction master.

---
 rtl/inst_axi_read_master_pkg.sv | 15 +
 rtl/inst_axi_read_master_if.sv | 35 +++
 rtl/inst_axi_read_master.sv | 135 +++++++++++++
 tb/tb_inst_axi_read_master.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_axi_read_master_pkg.sv
// Shared types and AXI encodings for the instruction-refill read master.
package inst_axi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        DONE
    } inst_rd_state_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

endpackage

// File: rtl/inst_axi_read_master_if.sv
// AXI4 read-address and read-data channels, seen from master and slave.
interface inst_axi_read_master_if #(
    parameter int ID_WIDTH = 4
) ();

    logic [ID_WIDTH-1:0] ARID;
    logic [31:0]         ARADDR;
    logic [7:0]          ARLEN;
    logic [2:0]          ARSIZE;
    logic [1:0]          ARBURST;
    logic                ARVALID;
    logic                ARREADY;

    logic [ID_WIDTH-1:0] RID;
    logic [31:0]         RDATA;
    logic [1:0]          RRESP;
    logic                RLAST;
    logic                RVALID;
    logic                RREADY;

    modport master (
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        input  ARREADY,
        input  RID, RDATA, RRESP, RLAST, RVALID,
        output RREADY
    );

    modport slave (
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        output ARREADY,
        output RID, RDATA, RRESP, RLAST, RVALID,
        input  RREADY
    );

endinterface

// File: rtl/inst_axi_read_master.sv
// Turns an I-cache line miss into one AXI4 INCR burst and hands each beat
// back to the cache as a single-cycle I_wait-low pulse.
module inst_axi_read_master
    import inst_axi_pkg::*;
#(
    parameter int ID_WIDTH  = 4,
    parameter int ARID_VAL  = 0,
    parameter int BURST_LEN = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        I_req,
    input  logic [31:0] I_addr,
    input  logic        I_write,
    output logic [31:0] I_out,
    output logic        I_wait,
    output logic        bus_err,
    inst_axi_read_master_if.master axi
);

    localparam logic [1:0]          LAST_BEAT = 2'(BURST_LEN - 1);
    localparam logic [ID_WIDTH-1:0] ID_VAL    = ID_WIDTH'(ARID_VAL);

    inst_rd_state_e state_q, state_d;
    logic [31:0]    araddr_q, araddr_d;
    logic           arvalid_q, arvalid_d;
    logic           rready_q, rready_d;
    logic [31:0]    i_out_q, i_out_d;
    logic           i_wait_q, i_wait_d;
    logic           bus_err_q, bus_err_d;
    logic [1:0]     beat_q, beat_d;

    logic r_fire;
    logic last_beat;
    logic beat_bad;

    assign r_fire    = axi.RVALID & rready_q;
    assign last_beat = (beat_q == LAST_BEAT);
    assign beat_bad  = (axi.RRESP != AXI_RESP_OKAY) ||
                       (axi.RID != ID_VAL) ||
                       (axi.RLAST != last_beat);

    always_comb begin
        state_d   = state_q;
        araddr_d  = araddr_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        i_out_d   = i_out_q;
        i_wait_d  = 1'b1;
        bus_err_d = bus_err_q;
        beat_d    = beat_q;

        case (state_q)
            IDLE: begin
                if (I_req) begin
                    if (I_write) begin
                        bus_err_d = 1'b1;
                        state_d   = DONE;
                    end else begin
                        araddr_d  = I_addr & 32'hFFFF_FFF0;
                        arvalid_d = 1'b1;
                        state_d   = ADDR;
                    end
                end
            end
            ADDR: begin
                if (axi.ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    beat_d    = 2'd0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                // A protocol error is flagged but the burst still runs to its
                // fourth accepted beat so the slave is never left mid-burst.
                if (r_fire) begin
                    i_out_d  = axi.RDATA;
                    i_wait_d = 1'b0;
                    beat_d   = beat_q + 2'd1;
                    if (beat_bad) begin
                        bus_err_d = 1'b1;
                    end
                    if (last_beat) begin
                        rready_d = 1'b0;
                        state_d  = DONE;
                    end
                end
            end
            DONE: begin
                if (!I_req) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            araddr_q  <= 32'h0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            i_out_q   <= 32'h0;
            i_wait_q  <= 1'b1;
            bus_err_q <= 1'b0;
            beat_q    <= 2'd0;
        end else begin
            state_q   <= state_d;
            araddr_q  <= araddr_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            i_out_q   <= i_out_d;
            i_wait_q  <= i_wait_d;
            bus_err_q <= bus_err_d;
            beat_q    <= beat_d;
        end
    end

    assign axi.ARID    = ID_VAL;
    assign axi.ARADDR  = araddr_q;
    assign axi.ARLEN   = 8'(BURST_LEN - 1);
    assign axi.ARSIZE  = AXI_SIZE_4B;
    assign axi.ARBURST = AXI_BURST_INCR;
    assign axi.ARVALID = arvalid_q;
    assign axi.RREADY  = rready_q;

    assign I_out   = i_out_q;
    assign I_wait  = i_wait_q;
    assign bus_err = bus_err_q;

endmodule

// File: tb/tb_inst_axi_read_master.sv
// Self-checking bench: table of refill scenarios, hand-written corner cases
// and randomized refills checked against a line-level model of the bridge.
module tb_inst_axi_read_master;
    import inst_axi_pkg::*;

    localparam logic [3:0] ARID_C = 4'd5;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        I_req = 1'b0;
    logic [31:0] I_addr = 32'h0;
    logic        I_write = 1'b0;
    logic [31:0] I_out;
    logic        I_wait;
    logic        bus_err;

    inst_axi_read_master_if #(.ID_WIDTH(4)) axi ();

    inst_axi_read_master #(
        .ID_WIDTH (4),
        .ARID_VAL (5),
        .BURST_LEN(4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .I_req  (I_req),
        .I_addr (I_addr),
        .I_write(I_write),
        .I_out  (I_out),
        .I_wait (I_wait),
        .bus_err(bus_err),
        .axi    (axi)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad = 0;
    logic model_err = 1'b0;

    typedef struct {
        logic        reset_first;
        logic [31:0] addr;
        int          ar_delay;
        int          gap;
        int          resp_bad;
        int          last_bad;
        int          id_bad;
        int          hold;
        logic [31:0] exp_araddr;
        logic        exp_err;
        logic [31:0] base;
    } refill_t;

    refill_t tbl[9];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_slave();
        axi.ARREADY = 1'b0;
        axi.RVALID  = 1'b0;
        axi.RDATA   = 32'h0;
        axi.RRESP   = AXI_RESP_OKAY;
        axi.RID     = ARID_C;
        axi.RLAST   = 1'b0;
    endtask

    task automatic do_reset();
        I_req   = 1'b0;
        I_write = 1'b0;
        idle_slave();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic check_reset_values();
        check_output("rst_arvalid", 32'(axi.ARVALID), 32'd0);
        check_output("rst_rready",  32'(axi.RREADY),  32'd0);
        check_output("rst_araddr",  axi.ARADDR,       32'h0);
        check_output("rst_i_out",   I_out,            32'h0);
        check_output("rst_i_wait",  32'(I_wait),      32'd1);
        check_output("rst_bus_err", 32'(bus_err),     32'd0);
        check_output("const_arlen",   32'(axi.ARLEN),   32'd3);
        check_output("const_arsize",  32'(axi.ARSIZE),  32'd2);
        check_output("const_arburst", 32'(axi.ARBURST), 32'd1);
        check_output("const_arid",    32'(axi.ARID),    32'd5);
    endtask

    // One complete line refill acting as the AXI slave; the cache side holds
    // I_req until all four words have come back, then for r.hold more cycles.
    task automatic apply_stimulus(input refill_t r, input logic exp_err);
        logic [31:0] words[4];
        logic [31:0] got[$];
        int          pulse_cyc[$];
        int          ar_wait = 0;
        int          sent = 0;
        int          gap_left = 0;
        int          cyc = 0;
        bit          ar_done = 0;
        bit          rready_seen = 0;
        bit          spacing_ok;

        for (int k = 0; k < 4; k++) words[k] = r.base + 32'(k);
        if (r.reset_first) do_reset();

        @(negedge clk);
        I_req   = 1'b1;
        I_addr  = r.addr;
        I_write = 1'b0;

        while (!(sent == 4 && got.size() >= 4) && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (!I_wait) begin
                got.push_back(I_out);
                pulse_cyc.push_back(cyc);
            end
            axi.ARREADY = 1'b0;
            if (!ar_done) begin
                check_output("arvalid_held", 32'(axi.ARVALID), 32'd1);
                check_output("araddr_held",  axi.ARADDR,       r.exp_araddr);
                if (ar_wait >= r.ar_delay) begin
                    axi.ARREADY = 1'b1;
                    ar_done = 1;
                end else begin
                    ar_wait++;
                end
            end else begin
                if (axi.RVALID && rready_seen) begin
                    sent++;
                    gap_left = r.gap;
                end
                axi.RVALID = 1'b0;
                if (sent < 4) begin
                    if (gap_left > 0) begin
                        gap_left--;
                    end else begin
                        axi.RVALID = 1'b1;
                        axi.RDATA  = words[sent];
                        axi.RRESP  = (sent == r.resp_bad) ? 2'b10 : AXI_RESP_OKAY;
                        axi.RID    = (sent == r.id_bad) ? (ARID_C ^ 4'h3) : ARID_C;
                        axi.RLAST  = (sent == 3) ^ (sent == r.last_bad);
                    end
                    rready_seen = axi.RREADY;
                end
            end
        end
        idle_slave();
        if (cyc >= 200) check_output("refill_timeout", 32'(cyc), 32'd0);

        for (int h = 0; h <= r.hold; h++) begin
            @(negedge clk);
            if (!I_wait) got.push_back(I_out);
            check_output("done_no_arvalid", 32'(axi.ARVALID), 32'd0);
        end
        I_req = 1'b0;

        check_output("word_count", 32'(got.size()), 32'd4);
        if (got.size() == 4) begin
            for (int k = 0; k < 4; k++) check_output($sformatf("word%0d", k), got[k], words[k]);
            if (r.gap == 0) begin
                check_output("pulses_consecutive", 32'(pulse_cyc[3] - pulse_cyc[0]), 32'd3);
            end else begin
                spacing_ok = 1;
                for (int k = 1; k < 4; k++) if (pulse_cyc[k] - pulse_cyc[k-1] < 2) spacing_ok = 0;
                check_output("pulses_isolated", 32'(spacing_ok), 32'd1);
            end
        end
        check_output("bus_err", 32'(bus_err), 32'(exp_err));
        @(negedge clk);
    endtask

    initial begin
        refill_t rr;
        int      kind;
        int      which;

        tbl[0] = '{1'b0, 32'h0000_1234, 0, 0, -1, -1, -1, 0, 32'h0000_1230, 1'b0, 32'h0000_00A0};
        tbl[1] = '{1'b0, 32'h8000_00FC, 5, 1, -1, -1, -1, 0, 32'h8000_00F0, 1'b0, 32'h0000_0B00};
        tbl[2] = '{1'b0, 32'h0000_2000, 0, 0,  1, -1, -1, 0, 32'h0000_2000, 1'b1, 32'h0000_0C00};
        tbl[3] = '{1'b0, 32'h0000_3008, 1, 0, -1, -1, -1, 5, 32'h0000_3000, 1'b1, 32'h0000_0D00};
        tbl[4] = '{1'b0, 32'h0000_3100, 0, 0, -1, -1, -1, 0, 32'h0000_3100, 1'b1, 32'h0000_0E00};
        tbl[5] = '{1'b1, 32'h0000_400C, 0, 0, -1,  2, -1, 0, 32'h0000_4000, 1'b1, 32'h0000_0F00};
        tbl[6] = '{1'b1, 32'h0000_5000, 0, 2, -1, -1,  0, 0, 32'h0000_5000, 1'b1, 32'h0000_1000};
        tbl[7] = '{1'b1, 32'hFFFF_FFFF, 2, 0, -1,  3, -1, 0, 32'hFFFF_FFF0, 1'b1, 32'h0000_1100};
        tbl[8] = '{1'b1, 32'h1234_5678, 0, 0, -1, -1, -1, 0, 32'h1234_5670, 1'b0, 32'h0000_1200};

        idle_slave();
        #12;
        check_reset_values();
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 9; i++) apply_stimulus(tbl[i], tbl[i].exp_err);

        // Write request is refused: no AR, error flagged, waits for I_req low.
        do_reset();
        @(negedge clk);
        I_req   = 1'b1;
        I_write = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_output("wr_no_arvalid", 32'(axi.ARVALID), 32'd0);
            check_output("wr_i_wait",     32'(I_wait),      32'd1);
        end
        check_output("wr_bus_err", 32'(bus_err), 32'd1);
        I_req   = 1'b0;
        I_write = 1'b0;
        @(negedge clk);
        rr = '{1'b0, 32'h0000_6004, 0, 0, -1, -1, -1, 0, 32'h0000_6000, 1'b1, 32'h0000_1300};
        apply_stimulus(rr, 1'b1);

        // Reset asserted while beat 2 is on the bus.
        do_reset();
        @(negedge clk);
        I_req  = 1'b1;
        I_addr = 32'h4000_0010;
        @(negedge clk);
        check_output("mid_arvalid", 32'(axi.ARVALID), 32'd1);
        axi.ARREADY = 1'b1;
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            axi.ARREADY = 1'b0;
            axi.RVALID  = 1'b1;
            axi.RDATA   = 32'h5500 + 32'(b);
            axi.RLAST   = 1'b0;
        end
        #1 rst = 1'b0;
        #1;
        check_output("mid_rst_arvalid", 32'(axi.ARVALID), 32'd0);
        check_output("mid_rst_rready",  32'(axi.RREADY),  32'd0);
        check_output("mid_rst_i_wait",  32'(I_wait),      32'd1);
        I_req = 1'b0;
        idle_slave();
        @(negedge clk);
        check_output("mid_rst_rready_next", 32'(axi.RREADY), 32'd0);
        check_output("mid_rst_i_out",       I_out,           32'h0);
        rst = 1'b1;
        rr = '{1'b0, 32'h4000_0018, 0, 0, -1, -1, -1, 0, 32'h4000_0010, 1'b0, 32'h0000_1400};
        apply_stimulus(rr, 1'b0);

        // Randomized refills against the sticky-error line model.
        model_err = 1'b0;
        for (int n = 0; n < 16; n++) begin
            rr.reset_first = ($urandom_range(0, 2) == 0);
            rr.addr        = $urandom;
            rr.ar_delay    = $urandom_range(0, 3);
            rr.gap         = $urandom_range(0, 2);
            rr.hold        = $urandom_range(0, 2);
            rr.resp_bad    = -1;
            rr.last_bad    = -1;
            rr.id_bad      = -1;
            kind  = $urandom_range(0, 5);
            which = $urandom_range(0, 3);
            if (kind == 0) rr.resp_bad = which;
            if (kind == 1) rr.last_bad = which;
            if (kind == 2) rr.id_bad   = which;
            rr.exp_araddr = {rr.addr[31:4], 4'b0000};
            rr.base       = $urandom;
            rr.exp_err    = 1'b0;
            if (rr.reset_first) model_err = 1'b0;
            if (kind <= 2) model_err = 1'b1;
            apply_stimulus(rr, model_err);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
